// File: rtl/sd_rx_pack16_if.sv
// Byte-stream and RAM narrow-port signals shared by the packer and its environment.
interface sd_rx_pack16_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_en;
  logic [1:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;

  modport master (
    input  in_valid, in_data, in_last,
    output in_ready, mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    output in_valid, in_data, in_last,
    input  in_ready, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sd_rx_pack16.sv
// Packs an accepted byte stream little-endian into halfwords and issues
// registered byte-enabled writes to the receive buffer narrow port.
module sd_rx_pack16 #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   limit_hw,
  sd_rx_pack16_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  byte_count
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   limit_q;
  logic [ADDR_W:0]   hw_idx;
  logic [7:0]        lo_reg;

  logic              accept;
  logic              wr_req;
  logic              wr_ok;
  logic [1:0]        wr_we;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;

  assign bus.in_ready = (state == LO) || (state == HI);
  assign accept       = bus.in_valid && bus.in_ready;

  // A write is due on every high byte, or on a low byte that ends the frame.
  assign wr_req  = accept && ((state == HI) || bus.in_last);
  assign wr_ok   = hw_idx < limit_q;
  assign wr_we   = (state == HI) ? 2'b11 : 2'b01;
  assign wr_data = (state == HI) ? {bus.in_data, lo_reg} : {8'h00, bus.in_data};
  assign wr_addr = ADDR_W'(base_q + hw_idx[ADDR_W-1:0]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      base_q       <= '0;
      limit_q      <= '0;
      hw_idx       <= '0;
      lo_reg       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      byte_count   <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 2'b00;
      bus.mem_addr <= '0;
      bus.mem_din  <= 16'h0000;
    end else begin
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 2'b00;
      bus.mem_addr <= '0;
      bus.mem_din  <= 16'h0000;
      done         <= 1'b0;

      if (accept && (byte_count != {CNT_W{1'b1}})) begin
        byte_count <= CNT_W'(byte_count + 1'b1);
      end

      // hw_idx stops at the limit, so every later write is also suppressed.
      if (wr_req) begin
        if (wr_ok) begin
          bus.mem_en   <= 1'b1;
          bus.mem_we   <= wr_we;
          bus.mem_addr <= wr_addr;
          bus.mem_din  <= wr_data;
          hw_idx       <= (ADDR_W+1)'(hw_idx + 1'b1);
        end else begin
          overflow <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            limit_q    <= limit_hw;
            hw_idx     <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            state      <= LO;
          end
        end
        LO: begin
          if (accept) begin
            lo_reg <= bus.in_data;
            state  <= bus.in_last ? FIN : HI;
          end
        end
        HI: begin
          if (accept) begin
            state <= bus.in_last ? FIN : LO;
          end
        end
        FIN: begin
          // First FIN cycle carries the final write; done follows it.
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_rx_pack16.sv
// Self-checking bench for sd_rx_pack16: directed frame table, reset corner
// cases and randomized frames against a halfword-list reference model.
module tb_sd_rx_pack16;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        we;
  } wr_t;

  typedef struct packed {
    int          base;
    int          limit;
    int          n;
    logic [63:0] b;
    int          nw;
    wr_t         w0;
    wr_t         wl;
    int          cnt;
    bit          ov;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   limit_hw;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [CNT_W-1:0]  byte_count;

  sd_rx_pack16_if #(.ADDR_W(ADDR_W)) bus ();

  sd_rx_pack16 #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .limit_hw   (limit_hw),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  bytes_q[$];
  int          exp_cnt;
  bit          exp_ov;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Capture issued writes; idle cycles must keep strobes and data at zero.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.mem_en === 1'b1) begin
        got_q.push_back('{bus.mem_addr, bus.mem_din, bus.mem_we});
      end else begin
        check("idle_we_din", {14'd0, bus.mem_we, bus.mem_din}, 32'd0);
      end
    end
  end

  // Reference: split the byte list into halfwords, keep those under the limit.
  function automatic void model(input int base, input int limit);
    int n   = bytes_q.size();
    int nhw = (n + 1) / 2;
    exp_q.delete();
    for (int i = 0; i < nhw; i++) begin
      logic [7:0] lo = bytes_q[2*i];
      logic [7:0] hi = (2*i + 1 < n) ? bytes_q[2*i+1] : 8'h00;
      logic [1:0] we = (2*i + 1 < n) ? 2'b11 : 2'b01;
      if (i < limit) exp_q.push_back('{ADDR_W'((base + i) % DEPTH), {hi, lo}, we});
    end
    exp_ov  = (nhw > limit);
    exp_cnt = (n > 65535) ? 65535 : n;
  endfunction

  task automatic run_frame(input int base, input int limit, input bit throttle, input bit mid_start);
    int n     = bytes_q.size();
    int i     = 0;
    int guard = 0;
    int m;
    model(base, limit);
    got_q.delete();
    @(negedge clk);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    limit_hw  = (ADDR_W+1)'(limit);
    @(negedge clk);
    start = 1'b0;
    while (i < n && guard < 4*n + 100) begin
      bus.in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = bytes_q[i];
      bus.in_last  = (i == n - 1);
      if (mid_start) begin
        start     = 1'($urandom_range(0, 1));
        base_addr = ADDR_W'($urandom);
        limit_hw  = (ADDR_W+1)'($urandom);
      end
      check("in_ready_in_frame", {31'd0, bus.in_ready}, 32'd1);
      if (bus.in_valid && bus.in_ready) i++;
      guard++;
      @(negedge clk);
    end
    if (i < n) check("byte_accept_timeout", i, n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    start        = 1'b0;
    check("done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("byte_count", {16'd0, byte_count}, exp_cnt);
    check("overflow", {31'd0, overflow}, {31'd0, exp_ov});
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("write_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) check($sformatf("write[%0d]", k), 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  function automatic vec_t mk(input int base, input int limit, input int n, input logic [63:0] b,
                              input int nw, input int a0, input int d0, input int we0,
                              input int al, input int dl, input int wel, input int cnt, input bit ov);
    vec_t v;
    v.base = base; v.limit = limit; v.n = n; v.b = b; v.nw = nw;
    v.w0 = '{ADDR_W'(a0), 16'(d0), 2'(we0)};
    v.wl = '{ADDR_W'(al), 16'(dl), 2'(wel)};
    v.cnt = cnt; v.ov = ov;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(32'h100, 16, 4, 64'h44332211,     2, 32'h100, 32'h2211, 3, 32'h101, 32'h4433, 3, 4, 0);
    vecs[1] = mk(0,       16, 3, 64'hC3B2A1,       2, 0,       32'hB2A1, 3, 1,       32'h00C3, 1, 3, 0);
    vecs[2] = mk(32'h20,  1,  6, 64'h060504030201, 1, 32'h20,  32'h0201, 3, 32'h20,  32'h0201, 3, 6, 1);
    vecs[3] = mk(8191,    4,  4, 64'h3CC3A55A,     2, 8191,    32'hA55A, 3, 0,       32'h3CC3, 3, 4, 0);
    vecs[4] = mk(32'h55,  0,  2, 64'hBBAA,         0, 0,       0,        0, 0,       0,        0, 2, 1);
    vecs[5] = mk(8190,    4,  8, 64'h0807060504030201, 4, 8190, 32'h0201, 3, 1,      32'h0807, 3, 8, 0);
    vecs[6] = mk(5,       1,  1, 64'h7E,           1, 5,       32'h007E, 1, 5,       32'h007E, 1, 1, 0);
    vecs[7] = mk(32'h10,  2,  5, 64'h0504030201,   2, 32'h10,  32'h0201, 3, 32'h11,  32'h0403, 3, 5, 1);

    rstn = 1'b0; start = 1'b0; base_addr = '0; limit_hw = '0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {bus.in_ready, bus.mem_en, bus.mem_we, busy, done, overflow, byte_count}, 32'd0);
    check("rst_addr_din", {3'd0, bus.mem_addr, bus.mem_din}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[j]) begin
      bytes_q.delete();
      for (int i = 0; i < vecs[j].n; i++) bytes_q.push_back(vecs[j].b[8*i +: 8]);
      run_frame(vecs[j].base, vecs[j].limit, 1'b0, 1'b0);
      check($sformatf("vec%0d_nw", j), got_q.size(), vecs[j].nw);
      check($sformatf("vec%0d_cnt", j), {16'd0, byte_count}, vecs[j].cnt);
      check($sformatf("vec%0d_ov", j), {31'd0, overflow}, {31'd0, vecs[j].ov});
      if (vecs[j].nw > 0 && got_q.size() > 0) begin
        check($sformatf("vec%0d_first", j), 32'(got_q[0]), 32'(vecs[j].w0));
        check($sformatf("vec%0d_last", j), 32'(got_q[got_q.size()-1]), 32'(vecs[j].wl));
      end
    end

    // Throttled replay of the even frame with stray starts mid-frame.
    bytes_q.delete();
    for (int i = 0; i < 4; i++) bytes_q.push_back(vecs[0].b[8*i +: 8]);
    run_frame(32'h100, 16, 1'b1, 1'b1);

    // Reset after one low byte: nothing written, everything cleared.
    got_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(32'h40); limit_hw = (ADDR_W+1)'(8);
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h99; bus.in_last = 1'b0;
    @(negedge clk);
    check("pre_rst_count", {16'd0, byte_count}, 32'd1);
    bus.in_data = 8'h55; bus.in_last = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("midrst_outputs", {bus.in_ready, bus.mem_en, bus.mem_we, busy, done, overflow, byte_count}, 32'd0);
    check("midrst_addr_din", {3'd0, bus.mem_addr, bus.mem_din}, 32'd0);
    check("midrst_no_write", got_q.size(), 0);
    rstn = 1'b1;
    bytes_q.delete();
    bytes_q.push_back(8'h3D);
    run_frame(32'h40, 8, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      int n = $urandom_range(1, 40);
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
      run_frame(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 25)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Long frame with no writes allowed: byte_count must stop at its maximum.
    bytes_q.delete();
    for (int i = 0; i < 65540; i++) bytes_q.push_back(8'($urandom));
    run_frame(0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_rx_pack16.md
# sd_rx_pack16

Byte-stream packer and write sequencer for the 16-bit port of the receive buffer RAM (8K x 16 narrow port / 2K x 64 wide port). Accepts one byte per cycle from the upstream receive engine, pairs bytes little-endian into halfwords, and issues registered halfword writes with per-byte enables on the narrow port. Reports the frame length and overflow to the control block, which then reads the frame out through the 64-bit port.

## Interface

Parameters:
- ADDR_W, 13, narrow-port halfword address width; buffer is 2^ADDR_W halfwords
- CNT_W, 16, width of byte_count

Ports:
- clk  in  1  sole clock; also drives the RAM narrow-port clock
- rstn  in  1  synchronous active-low reset
- start  in  1  arm a new frame; sampled only in IDLE
- base_addr  in  ADDR_W  halfword address of the first write, latched on start
- limit_hw  in  ADDR_W+1  maximum halfwords for the frame, latched on start; 0 means no writes allowed
- in_valid  in  1  byte present
- in_data  in  8  byte value
- in_last  in  1  final byte of frame, qualified by in_valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- mem_en  out  1  RAM narrow-port enable
- mem_we  out  2  byte write enables; bit0 = bits [7:0], bit1 = bits [15:8]
- mem_addr  out  ADDR_W  halfword address
- mem_din  out  16  write data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame end
- overflow  out  1  frame exceeded limit_hw; held until next start
- byte_count  out  CNT_W  bytes accepted in current/last frame; held until next start

## Operation

- States: IDLE, LO (awaiting low byte), HI (awaiting high byte), FIN.
- IDLE: in_ready=0. On start: latch base_addr, limit_hw; clear byte_count, overflow, halfword index hw_idx; go LO.
- LO: in_ready=1. On accept: store byte in lo_reg, byte_count+1. If in_last: issue partial write (mem_we=2'b01, mem_din={8'h00,byte}), go FIN; else go HI.
- HI: in_ready=1. On accept: issue full write (mem_we=2'b11, mem_din={byte,lo_reg}), byte_count+1. If in_last go FIN, else go LO.
- Each issued write: mem_addr = (base + hw_idx) mod 2^ADDR_W; hw_idx increments after the write.
- Limit: a write with hw_idx >= limit_hw is suppressed (mem_en=0, mem_we=0) and sets overflow; bytes are still accepted and counted until in_last.
- FIN: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. in_valid in IDLE/FIN is ignored (not accepted).
- byte_count saturates at 2^CNT_W-1; no wrap.
- mem_en is high only in write cycles; mem_we=0 whenever mem_en=0; mem_din is don't-care then but driven 0.

## Timing

- All outputs registered except in_ready, which decodes state (LO/HI).
- Write latency: RAM write strobes appear the cycle after the accepting handshake; at most one write per two accepted bytes, except the terminating partial write.
- done asserts the cycle after the write carrying the last byte (two cycles after the in_last handshake); byte_count and overflow are final when done is high.
- Minimum frame turnaround: start accepted in the cycle after done.
- Back-to-back bytes at full rate: no bubbles; in_ready never drops within a frame.
- Address wrap: base_addr=8190 with 4 halfwords writes 8190, 8191, 0, 1.
- Reset (rstn=0 at any clock, including mid-frame): state IDLE; in_ready, mem_en, mem_we, mem_addr, mem_din, busy, done, overflow, byte_count, lo_reg, hw_idx all 0; pending low byte discarded, no write issued.

## Test plan

- Even frame: start base=0x100, limit=16; bytes 0x11,0x22,0x33,0x44 (last on 0x44) -> writes addr 0x100 data 0x2211 we=11, addr 0x101 data 0x4433 we=11; done pulse; byte_count=4; overflow=0.
- Odd frame: 3 bytes 0xA1,0xB2,0xC3 from base 0 -> addr 0 data 0xB2A1 we=11, addr 1 data 0x00C3 we=01; byte_count=3.
- Limit: limit=1, 6 bytes -> one write at base, two suppressed; overflow=1; byte_count=6; done pulses.
- Wrap: base=8191, 4 bytes -> writes to 8191 then 0.
- Throttled input: in_valid toggled randomly, start asserted mid-frame -> data/addresses identical to unthrottled run; mid-frame start ignored.
- Reset mid-frame after one low byte -> no write issued, all outputs 0 next cycle; subsequent frame correct from IDLE.
